// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the multi-cycle ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_div.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// done marks the final iteration; quotient/remainder then carry that step's result.
module alu_div
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] quo;
  logic [DATA_WIDTH-1:0] dvs;
  logic [CW-1:0]         cnt;
  logic                  busy_q;

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;
  logic                  fits;

  always_comb begin
    shifted   = {acc, quo[DATA_WIDTH-1]};
    diff      = shifted - {1'b0, dvs};
    fits      = (shifted >= {1'b0, dvs});
    remainder = fits ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    quotient  = {quo[DATA_WIDTH-2:0], fits};
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      quo    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      quo    <= a;
      dvs    <= b;
      cnt    <= CW'(DATA_WIDTH);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc <= remainder;
      quo <= quotient;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1))
        busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake on both sides.
// Optional zero/carry flags are built when ALU_MC_FLAGS_EN is defined.
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int HIGH       = DATA_WIDTH - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    oc,
  input  logic [HIGH:0] a,
  input  logic [HIGH:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [HIGH:0] f,
  output logic [HIGH:0] rem,
  output logic          err,
  output logic          zero,
  output logic          carry
);

  state_t state, state_next;

  logic          accept;
  logic          div_start;
  logic          div_done;
  logic          div_busy;
  logic [HIGH:0] div_q;
  logic [HIGH:0] div_r;

  logic [HIGH:0] res_f;
  logic [HIGH:0] res_rem;
  logic          res_err;

  logic          load;
  logic [HIGH:0] f_next;
  logic [HIGH:0] rem_next;
  logic          err_next;

  assign accept    = in_valid && in_ready;
  assign div_start = accept && (oc == OP_DIV) && (b != '0);

  alu_div #(.DATA_WIDTH(DATA_WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .a         (a),
    .b         (b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r),
    .busy      (div_busy)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept)
          state_next = div_start ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (div_done)
          state_next = ST_DONE;
      end
      ST_DONE: begin
        if (accept)
          state_next = div_start ? ST_BUSY : ST_DONE;
        else if (out_ready)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    out_valid = (state == ST_DONE);
  end

  // Single-cycle results; the div entry only matters for the b==0 case.
  always_comb begin
    res_f   = '0;
    res_rem = '0;
    res_err = 1'b0;
    case (oc)
      OP_ADD: res_f = a + b;
      OP_SUB: res_f = a - b;
      OP_MUL: res_f = a * b;
      OP_DIV: begin
        res_f   = '1;
        res_rem = a;
        res_err = 1'b1;
      end
      OP_NOT: res_f = ~a;
      OP_XOR: res_f = a ^ b;
      OP_OR:  res_f = a | b;
      OP_AND: res_f = a & b;
      default: res_f = '0;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    f_next   = res_f;
    rem_next = res_rem;
    err_next = res_err;
    if (accept && !div_start) begin
      load = 1'b1;
    end else if ((state == ST_BUSY) && div_done) begin
      load     = 1'b1;
      f_next   = div_q;
      rem_next = div_r;
      err_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f   <= '0;
      rem <= '0;
      err <= 1'b0;
    end else if (load) begin
      f   <= f_next;
      rem <= rem_next;
      err <= err_next;
    end
  end

`ifdef ALU_MC_FLAGS_EN
  logic res_carry;
  logic carry_next;

  always_comb begin
    res_carry = 1'b0;
    case (oc)
      OP_ADD:  res_carry = ({1'b0, a} + {1'b0, b}) > {1'b0, {DATA_WIDTH{1'b1}}};
      OP_SUB:  res_carry = (a < b);
      default: res_carry = 1'b0;
    endcase
    carry_next = (accept && !div_start) ? res_carry : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero  <= 1'b0;
      carry <= 1'b0;
    end else if (load) begin
      zero  <= (f_next == '0);
      carry <= carry_next;
    end
  end
`else
  assign zero  = 1'b0;
  assign carry = 1'b0;
`endif

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: operand/result width, legal range 4..64.
REQ-002 SHALL have derived parameter HIGH, default DATA_WIDTH-1: MSB index.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port oc  input  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 not a, 101 xor, 110 or, 111 and.
REQ-008 SHALL have ports a, b  input  DATA_WIDTH each  unsigned operands.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port f  output  DATA_WIDTH  result.
REQ-012 SHALL have port rem  output  DATA_WIDTH  div remainder; 0 for other ops.
REQ-013 SHALL have port err  output  1  divide-by-zero indication.
REQ-014 SHALL have ports zero, carry  output  1 each  status flags (see Configuration).

Function
REQ-015 SHALL accept a request on a cycle where in_valid && in_ready; operands and oc captured in that cycle.
REQ-016 SHALL implement FSM IDLE -> (div, b!=0) BUSY -> DONE; IDLE -> (other op or b==0 div) DONE; DONE -> IDLE on out_ready without new accept.
REQ-017 SHALL assert in_ready in IDLE, and in DONE when out_ready=1 (result consumed and new request accepted same cycle); deassert in BUSY and in DONE with out_ready=0.
REQ-018 SHALL present non-div results with out_valid at cycle N+1 for acceptance at cycle N.
REQ-019 SHALL compute div by iterative unsigned restoring division, one quotient bit per cycle, out_valid at N+DATA_WIDTH+1.
REQ-020 SHALL compute add/sub/mul modulo 2^DATA_WIDTH; mul keeps low DATA_WIDTH bits; div quotient truncates.
REQ-021 SHALL on div with b==0: f=all ones, rem=a, err=1, out_valid at N+1; err=0 for all other results.
REQ-022 SHALL hold f, rem, err, flags and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL ignore in_valid, oc, a, b changes while in_ready=0.

Reset
REQ-024 SHALL on rst=1 at any clock edge, including mid-divide: state IDLE, out_valid=0, f=0, rem=0, err=0, zero=0, carry=0; in-flight op discarded.
REQ-025 SHALL present in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-026 SHALL use macro ALU_MC_FLAGS_EN: defined -> zero=(f==0), carry=add carry-out or sub borrow (a<b), 0 for other ops, registered with f; undefined -> zero and carry tied to 0, no flag logic.

Structure
REQ-027 SHALL place opcode localparams (OP_ADD..OP_AND) and FSM state encodings in shared package alu_pkg.
REQ-028 SHALL place iterative divider in sub-module alu_div (start, a, b -> done, quotient, remainder, busy).

Verification
REQ-029 SHALL cover: DATA_WIDTH=16, add 0xFFFF+0x0001 -> f=0x0000, carry=1, zero=1 (flags build), out_valid at N+1.
REQ-030 SHALL cover: div 100/7 -> f=0x000E, rem=0x0002, err=0, in_ready=0 during BUSY, out_valid at N+17.
REQ-031 SHALL cover: div 0x1234/0 -> f=0xFFFF, rem=0x1234, err=1, out_valid at N+1.
REQ-032 SHALL cover: mul 0x0100*0x0100 with out_ready=0 five cycles -> f=0x0000 held, out_valid held, in_ready=0; release -> accepted once.
REQ-033 SHALL cover: rst asserted 5 cycles into div -> next cycle out_valid=0, in_ready=1, following add 3+4 -> f=0x0007.
REQ-034 SHALL cover: back-to-back xor 0x00FF^0x0F0F then or 0x00F0|0x0F00 with out_ready=1 -> f=0x0FF0 then 0x0FF0 on consecutive cycles.
